// File: rtl/otter_demux_pkg.sv
// Shared constants and types for the buffered 1-to-N result demultiplexer.
package otter_demux_pkg;

  localparam int unsigned SEL_W       = 3;
  localparam int unsigned NUM_OUT_MAX = 8;
  localparam int unsigned ERR_CNT_W   = 8;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'hFF;

  typedef logic [SEL_W-1:0]     sel_t;
  typedef logic [ERR_CNT_W-1:0] err_cnt_t;

endpackage

// File: rtl/demux_slot.sv
// One-entry holding register with valid/ready handshake; a load may coincide with a drain.
module demux_slot #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_data
);

  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  // A load is only issued when the slot is empty or draining this cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_data  <= i_data;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/demux1_8_buf.sv
// Buffered 1-to-NUM_OUT demultiplexer with per-channel holding slots and sticky select error.
// Optional macro DEMUX_ERR_CNT_EN enables a saturating dropped-word counter on err_cnt.
module demux1_8_buf
  import otter_demux_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned NUM_OUT = 6
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [WIDTH-1:0]                in_data,
  input  logic [SEL_W-1:0]                in_sel,
  output logic [NUM_OUT-1:0]              out_valid,
  input  logic [NUM_OUT-1:0]              out_ready,
  output logic [NUM_OUT-1:0][WIDTH-1:0]   out_data,
  output logic                            sel_err,
  output logic [ERR_CNT_W-1:0]            err_cnt
);

  localparam logic [SEL_W:0] NUM_OUT_L = (SEL_W + 1)'(NUM_OUT);

  logic                   w_legal;
  logic                   w_accept;
  logic                   w_acc_illegal;
  logic [NUM_OUT_MAX-1:0] w_valid_pad;
  logic [NUM_OUT_MAX-1:0] w_ready_pad;
  logic                   r_sel_err;

  // Pad per-channel status to the full select range so in_sel indexing stays in bounds.
  always_comb begin
    w_valid_pad                = '0;
    w_ready_pad                = '0;
    w_valid_pad[NUM_OUT-1:0]   = out_valid;
    w_ready_pad[NUM_OUT-1:0]   = out_ready;
  end

  always_comb begin
    w_legal = ({1'b0, in_sel} < NUM_OUT_L);
    if (RST)          in_ready = 1'b0;
    else if (w_legal) in_ready = !w_valid_pad[in_sel] || w_ready_pad[in_sel];
    else              in_ready = 1'b1;
  end

  assign w_accept      = in_valid && in_ready;
  assign w_acc_illegal = w_accept && !w_legal;

  for (genvar g = 0; g < NUM_OUT; g++) begin : g_slot
    logic w_load;
    assign w_load = w_accept && w_legal && (in_sel == SEL_W'(g));

    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk     (CLK),
      .rst     (RST),
      .i_load  (w_load),
      .i_data  (in_data),
      .i_ready (out_ready[g]),
      .o_valid (out_valid[g]),
      .o_data  (out_data[g])
    );
  end

  always_ff @(posedge CLK) begin
    if (RST)                r_sel_err <= 1'b0;
    else if (w_acc_illegal) r_sel_err <= 1'b1;
  end

  assign sel_err = r_sel_err;

`ifdef DEMUX_ERR_CNT_EN
  err_cnt_t r_err_cnt;

  always_ff @(posedge CLK) begin
    if (RST)
      r_err_cnt <= '0;
    else if (w_acc_illegal && (r_err_cnt != ERR_CNT_MAX))
      r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
  end

  assign err_cnt = r_err_cnt;
`else
  assign err_cnt = '0;
`endif

endmodule
